// File: rtl/qick_cmd_exec.sv
// Command executor: latches an opcode plus data words, acks once, then streams a header and nw data words.
// Latency: ack one cycle after the accepting edge; first header valid one cycle after ack.
// Backpressure: tx_vld_o/tx_dt_o/tx_last_o hold while tx_rdy_i is low; new commands wait until IDLE.
module qick_cmd_exec #(
    parameter int OP_DW  = 5,
    parameter int DT_QTY = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_req_i,
    output logic                   cmd_ack_o,
    input  logic [OP_DW-1:0]       cmd_op_i,
    input  logic [DT_QTY*32-1:0]   cmd_dt_i,
    output logic                   tx_vld_o,
    input  logic                   tx_rdy_i,
    output logic [31:0]            tx_dt_o,
    output logic                   tx_last_o,
    output logic                   busy_o,
    output logic [7:0]             exec_cnt_do
);

    localparam int         IW     = (DT_QTY > 1) ? $clog2(DT_QTY) : 1;
    localparam logic [7:0] DT_MAX = 8'(DT_QTY);

    typedef enum logic [1:0] {IDLE, ACK, HDR, DATA} state_t;

    typedef struct packed {
        logic [7:0]  magic;
        logic [7:0]  nw;
        logic [15:0] op;
    } hdr_t;

    state_t           state_q, state_d;
    logic [OP_DW-1:0] op_q;
    logic [31:0]      dt_q [DT_QTY];
    logic [7:0]       nw_q;
    logic [7:0]       idx_q;
    logic [3:0]       nop_cnt, frm_cnt;
    logic [7:0]       nw_in;
    logic             ld, nop_inc, frm_inc, idx_clr, idx_inc;
    hdr_t             hdr;

    // Word count is clipped to the number of data words actually carried.
    assign nw_in = ({5'd0, cmd_op_i[2:0]} > DT_MAX) ? DT_MAX : {5'd0, cmd_op_i[2:0]};
    assign hdr   = '{magic: 8'hA5, nw: nw_q, op: 16'(op_q)};
    assign exec_cnt_do = {nop_cnt, frm_cnt};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q <= '0;
            nw_q <= '0;
            for (int i = 0; i < DT_QTY; i++) begin
                dt_q[i] <= '0;
            end
        end else if (ld) begin
            op_q <= cmd_op_i;
            nw_q <= nw_in;
            for (int i = 0; i < DT_QTY; i++) begin
                dt_q[i] <= cmd_dt_i[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q   <= '0;
            nop_cnt <= '0;
            frm_cnt <= '0;
        end else begin
            if (idx_clr) begin
                idx_q <= '0;
            end else if (idx_inc) begin
                idx_q <= idx_q + 8'd1;
            end
            if (nop_inc) begin
                nop_cnt <= nop_cnt + 4'd1;
            end
            if (frm_inc) begin
                frm_cnt <= frm_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ld        = 1'b0;
        nop_inc   = 1'b0;
        frm_inc   = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        cmd_ack_o = 1'b0;
        tx_vld_o  = 1'b0;
        tx_dt_o   = '0;
        tx_last_o = 1'b0;
        busy_o    = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (cmd_req_i) begin
                    ld      = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                cmd_ack_o = 1'b1;
                if (op_q == '0) begin
                    nop_inc = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = HDR;
                end
            end
            HDR: begin
                tx_vld_o  = 1'b1;
                tx_dt_o   = hdr;
                tx_last_o = (nw_q == 8'd0);
                if (tx_rdy_i) begin
                    if (nw_q == 8'd0) begin
                        frm_inc = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_clr = 1'b1;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                tx_vld_o  = 1'b1;
                tx_dt_o   = dt_q[idx_q[IW-1:0]];
                tx_last_o = (idx_q == nw_q - 8'd1);
                if (tx_rdy_i) begin
                    if (idx_q == nw_q - 8'd1) begin
                        frm_inc = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_qick_cmd_exec.sv
// Bench for qick_cmd_exec: directed frames, a vector table, randomized commands and reset corner cases.
// Expected stream contents come from the command rules (header format, clipped word count, counters).
module tb_qick_cmd_exec;

    logic         clk;
    logic         rst_n;
    logic         cmd_req;
    logic         cmd_ack;
    logic [4:0]   cmd_op;
    logic [127:0] cmd_dt;
    logic         tx_vld;
    logic         tx_rdy;
    logic [31:0]  tx_dt;
    logic         tx_last;
    logic         busy;
    logic [7:0]   exec_cnt;

    int n_pass = 0;
    int n_chk  = 0;
    int nop_m  = 0;
    int frm_m  = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] hdr;
        int          nw;
    } vec_t;

    vec_t vecs [10];

    qick_cmd_exec #(.OP_DW(5), .DT_QTY(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_req_i   (cmd_req),
        .cmd_ack_o   (cmd_ack),
        .cmd_op_i    (cmd_op),
        .cmd_dt_i    (cmd_dt),
        .tx_vld_o    (tx_vld),
        .tx_rdy_i    (tx_rdy),
        .tx_dt_o     (tx_dt),
        .tx_last_o   (tx_last),
        .busy_o      (busy),
        .exec_cnt_do (exec_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int ref_nw(input logic [4:0] op);
        int n;
        n = int'(op) % 8;
        return (n > 4) ? 4 : n;
    endfunction

    function automatic logic [31:0] ref_hdr(input logic [4:0] op);
        return 32'hA500_0000 + (ref_nw(op) * 65536) + int'(op);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_ack"}, cmd_ack, 1'b0);
        chk1({tag, "_vld"}, tx_vld, 1'b0);
        chk1({tag, "_last"}, tx_last, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_dt"}, tx_dt, 32'h0);
        chk({tag, "_cnt"}, {24'h0, exec_cnt}, 32'h0);
    endtask

    // Entered and left at a falling edge with the DUT idle.
    task automatic do_cmd(input logic [4:0] op, input logic [127:0] dt, input logic [31:0] exp_hdr,
                          input int exp_nw, input int stall_k, input int stall_n, input bit rand_bp);
        int k, stalls, guard, run;
        logic [31:0] exp_w;
        logic        exp_l;
        chk1("pre_idle", busy, 1'b0);
        cmd_req = 1'b1;
        cmd_op  = op;
        cmd_dt  = dt;
        tx_rdy  = 1'b1;
        @(negedge clk);
        chk1("ack_pulse", cmd_ack, 1'b1);
        chk1("ack_busy", busy, 1'b1);
        chk1("ack_no_vld", tx_vld, 1'b0);
        cmd_req = 1'b0;
        cmd_op  = 5'($urandom());
        cmd_dt  = rnd128();
        if (op == 5'd0) begin
            @(negedge clk);
            chk1("nop_ack_drop", cmd_ack, 1'b0);
            chk1("nop_busy_drop", busy, 1'b0);
            chk1("nop_no_vld", tx_vld, 1'b0);
            nop_m = (nop_m + 1) % 16;
        end else begin
            k = 0; stalls = 0; guard = 0; run = 0;
            while (k <= exp_nw && guard < 64) begin
                @(negedge clk);
                guard++;
                if (k == 0) exp_w = exp_hdr;
                else        exp_w = dt[(k-1)*32 +: 32];
                exp_l = (k == exp_nw);
                chk1("stream_vld", tx_vld, 1'b1);
                chk("stream_dt", tx_dt, exp_w);
                chk1("stream_last", tx_last, exp_l);
                chk1("stream_no_ack", cmd_ack, 1'b0);
                cmd_op = 5'($urandom());
                cmd_dt = rnd128();
                if (k == stall_k && stalls < stall_n) begin
                    tx_rdy = 1'b0;
                    stalls++;
                end else if (rand_bp && run < 3 && $urandom_range(0, 2) == 0) begin
                    tx_rdy = 1'b0;
                    run++;
                end else begin
                    tx_rdy = 1'b1;
                    run = 0;
                    k++;
                end
            end
            if (guard >= 64) begin
                n_chk++;
                $display("FAIL frame_timeout: %0d words seen, required %0d", k, exp_nw + 1);
            end
            @(negedge clk);
            chk1("frame_end_busy", busy, 1'b0);
            chk1("frame_end_vld", tx_vld, 1'b0);
            frm_m = (frm_m + 1) % 16;
        end
        chk("exec_cnt", {24'h0, exec_cnt}, {24'h0, nop_m[3:0], frm_m[3:0]});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst");
        nop_m = 0;
        frm_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [127:0] dt;
        logic [4:0]   op;

        vecs[0] = '{5'h01, 32'hA501_0001, 1};
        vecs[1] = '{5'h02, 32'hA502_0002, 2};
        vecs[2] = '{5'h04, 32'hA504_0004, 4};
        vecs[3] = '{5'h05, 32'hA504_0005, 4};
        vecs[4] = '{5'h08, 32'hA500_0008, 0};
        vecs[5] = '{5'h0A, 32'hA502_000A, 2};
        vecs[6] = '{5'h1C, 32'hA504_001C, 4};
        vecs[7] = '{5'h1F, 32'hA504_001F, 4};
        vecs[8] = '{5'h00, 32'h0000_0000, 0};
        vecs[9] = '{5'h10, 32'hA500_0010, 0};

        rst_n   = 1'b0;
        cmd_req = 1'b0;
        cmd_op  = 5'h1F;
        cmd_dt  = rnd128();
        tx_rdy  = 1'b0;

        // Reset state, then idle with no request after release.
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_all_zero("post_reset");
        end

        dt = {32'd44, 32'd33, 32'd22, 32'd11};
        do_cmd(5'h03, dt, 32'hA503_0003, 3, -1, 0, 1'b0);
        chk("basic_cnt", {24'h0, exec_cnt}, 32'h01);

        do_cmd(5'h07, rnd128(), 32'hA504_0007, 4, -1, 0, 1'b0);

        do_cmd(5'h03, dt, 32'hA503_0003, 3, 2, 3, 1'b0);

        do_reset();
        do_cmd(5'h00, rnd128(), 32'h0, 0, -1, 0, 1'b0);
        chk("nop_cnt", {24'h0, exec_cnt}, 32'h10);

        // Request held high across a NOP is taken again as soon as IDLE returns.
        cmd_req = 1'b1;
        cmd_op  = 5'h00;
        @(negedge clk);
        chk1("b2b_ack1", cmd_ack, 1'b1);
        @(negedge clk);
        chk1("b2b_gap_ack", cmd_ack, 1'b0);
        chk1("b2b_gap_busy", busy, 1'b0);
        @(negedge clk);
        chk1("b2b_ack2", cmd_ack, 1'b1);
        cmd_req = 1'b0;
        @(negedge clk);
        chk1("b2b_end_busy", busy, 1'b0);
        nop_m = (nop_m + 2) % 16;
        chk("b2b_cnt", {24'h0, exec_cnt}, {24'h0, nop_m[3:0], frm_m[3:0]});

        for (int i = 0; i < 10; i++) begin
            do_cmd(vecs[i].op, rnd128(), vecs[i].hdr, vecs[i].nw, -1, 0, 1'b0);
        end

        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom());
            do_cmd(op, rnd128(), ref_hdr(op), ref_nw(op), -1, 0, 1'b1);
        end

        // Reset in the middle of a data phase, request kept high throughout.
        dt = rnd128();
        cmd_req = 1'b1;
        cmd_op  = 5'h03;
        cmd_dt  = dt;
        tx_rdy  = 1'b1;
        @(negedge clk);
        chk1("mid_ack", cmd_ack, 1'b1);
        @(negedge clk);
        chk("mid_hdr", tx_dt, 32'hA503_0003);
        @(negedge clk);
        chk("mid_data0", tx_dt, dt[31:0]);
        chk1("mid_data_vld", tx_vld, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        nop_m = 0;
        frm_m = 0;
        dt = rnd128();
        cmd_op = 5'h01;
        cmd_dt = dt;
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(5'h01, dt, 32'hA501_0001, 1, -1, 0, 1'b0);
        chk("mid_resume_cnt", {24'h0, exec_cnt}, 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
